// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the pipelined RV32I control unit.
//   - RV32I opcode / funct3 / funct7 constants
//   - alu_op_e, pc_src_e, wb_sel_e and imm_sel_e encodings
//   - ctrl_word_t: the control word carried from ID into EX
//   - CTRL_BUBBLE: the all-zero "do nothing" control word
//   - branch_taken(): conditional-branch evaluation from stored funct3 and ALU flags
package cu_pkg;

  // Field widths fixed by the RV32I encoding
  localparam int OP_CODE_W = 7;
  localparam int FUNCT3_W  = 3;
  localparam int FUNCT7_W  = 7;
  localparam int ALU_OP_W  = 4;

  // Major opcodes
  localparam logic [OP_CODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OP_CODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OP_CODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OP_CODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OP_CODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OP_CODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OP_CODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OP_CODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OP_CODE_W-1:0] OPC_AUIPC  = 7'b0010111;

  // funct3 values
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BEQ     = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT     = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE     = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU    = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU    = 3'b111;
  localparam logic [FUNCT3_W-1:0] F3_LD      = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_SW      = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_JALR    = 3'b000;

  // funct7 values
  localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

  // ALU operation select: {funct7[5], funct3}
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

  // alu_op is kept as a plain vector: R-type decode can produce
  // {funct7[5], funct3} combinations that have no alu_op_e name.
  typedef struct packed {
    logic                reg_wr_en;
    logic                mem_rd_en;
    logic                mem_wr_en;
    logic                alu_src_sel;
    logic                alu_a_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                is_branch;
    logic                is_jal;
    logic                is_jalr;
    logic [FUNCT3_W-1:0] funct3;
    wb_sel_e             wb_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // Conditional-branch outcome; funct3 010/011 are never taken.
  function automatic logic branch_taken(
    input logic [FUNCT3_W-1:0] funct3,
    input logic                zero,
    input logic                lt,
    input logic                ltu
  );
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: purely combinational RV32I decode of the ID-stage instruction.
// Ports:
//   op_code, funct3, funct7  in   instruction fields from IF/ID
//   ctrl                     out  decoded control word (CTRL_BUBBLE for unknown opcodes)
//   imm_sel                  out  immediate format for the ID-stage immediate generator
//   known                    out  opcode is one of the nine RV32I major opcodes
//   illegal                  out  unknown opcode or a reserved funct3/funct7 pattern
// The illegal flag is always computed; the top decides whether to act on it.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [OP_CODE_W-1:0] op_code,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic [FUNCT7_W-1:0]  funct7,
  output ctrl_word_t           ctrl,
  output imm_sel_e             imm_sel,
  output logic                 known,
  output logic                 illegal
);

  logic bad_funct;

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    imm_sel   = IMM_I;
    known     = 1'b1;
    bad_funct = 1'b0;

    case (op_code)
      OPC_OP: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu_op    = {funct7[5], funct3};
        ctrl.wb_sel    = WB_ALU;
        // Only ADD/SUB and SRL/SRA have an alternate (0100000) form
        bad_funct = !((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) &&
                       ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        // funct7 bits are immediate bits except for the right shifts
        ctrl.alu_op      = {(funct3 == F3_SRL_SRA) ? funct7[5] : 1'b0, funct3};
        ctrl.wb_sel      = WB_ALU;
        bad_funct = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                    ((funct3 == F3_SRL_SRA) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OPC_LOAD: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.mem_rd_en   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.funct3      = funct3;
        ctrl.wb_sel      = WB_MEM;
        bad_funct = (funct3 == F3_LD) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl.mem_wr_en   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.funct3      = funct3;
        imm_sel          = IMM_S;
        bad_funct = (funct3 > F3_SW);
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.funct3    = funct3;
        imm_sel        = IMM_B;
      end
      OPC_JAL: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.is_jal      = 1'b1;
        ctrl.alu_a_sel   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.wb_sel      = WB_PC4;
        imm_sel          = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.is_jalr     = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.wb_sel      = WB_PC4;
        bad_funct = (funct3 != F3_JALR);
      end
      OPC_LUI: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.wb_sel      = WB_IMM;
        imm_sel          = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.alu_a_sel   = 1'b1;
        ctrl.alu_src_sel = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.wb_sel      = WB_ALU;
        imm_sel          = IMM_U;
      end
      default: begin
        known = 1'b0;
      end
    endcase

    illegal = !known || bad_funct;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: pipelined RV32I control.
// Decodes the ID-stage instruction, carries the control word through
// ID/EX, EX/MEM and MEM/WB, resolves branches/jumps in EX and inserts
// bubbles into ID/EX on flush, stall, empty slots and rejected instructions.
// Ports:
//   i_clk, i_reset_n                      clock, asynchronous active-low reset
//   i_instr_valid, i_op_code,
//   i_funct3, i_funct7                    ID-stage instruction
//   i_stall                               load-use hazard: bubble into ID/EX
//   i_alu_zero_flag, i_alu_lt_flag,
//   i_alu_ltu_flag                        EX-stage ALU compare flags
//   o_id_imm_sel                          immediate format (combinational, ID)
//   o_ex_alu_src_sel, o_ex_alu_a_sel,
//   o_ex_alu_op                           EX operand/operation selects
//   o_ex_pc_src, o_ex_flush               next-PC select and IF/ID flush (EX)
//   o_mem_rd_en, o_mem_wr_en, o_mem_size  data-memory controls (MEM)
//   o_wb_reg_wr_en, o_wb_result_sel       register-file write controls (WB)
//   o_illegal_insn                        illegal instruction in EX slot
// Build option: CU_ILLEGAL_INSN_DET_EN enables illegal-instruction detection;
// without it only unrecognised opcodes are bubbled and o_illegal_insn is 0.
module pipeline_control_unit
  import cu_pkg::*;
#(
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7,
  parameter int ALU_OP_WIDTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_instr_valid,
  input  logic [OP_CODE_WIDTH-1:0] i_op_code,
  input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
  input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
  input  logic                     i_stall,
  input  logic                     i_alu_zero_flag,
  input  logic                     i_alu_lt_flag,
  input  logic                     i_alu_ltu_flag,
  output logic [2:0]               o_id_imm_sel,
  output logic                     o_ex_alu_src_sel,
  output logic                     o_ex_alu_a_sel,
  output logic [ALU_OP_WIDTH-1:0]  o_ex_alu_op,
  output logic [1:0]               o_ex_pc_src,
  output logic                     o_ex_flush,
  output logic                     o_mem_rd_en,
  output logic                     o_mem_wr_en,
  output logic [FUNCT3_WIDTH-1:0]  o_mem_size,
  output logic                     o_wb_reg_wr_en,
  output logic [1:0]               o_wb_result_sel,
  output logic                     o_illegal_insn
);

  // ---------------------------------------------------------------------
  // ID: decode
  // ---------------------------------------------------------------------
  ctrl_word_t dec_ctrl;
  imm_sel_e   dec_imm_sel;
  logic       dec_known;
  logic       dec_illegal;

  cu_decoder u_decoder (
    .op_code (i_op_code),
    .funct3  (i_funct3),
    .funct7  (i_funct7),
    .ctrl    (dec_ctrl),
    .imm_sel (dec_imm_sel),
    .known   (dec_known),
    .illegal (dec_illegal)
  );

  assign o_id_imm_sel = dec_imm_sel;

  // reject_insn: the decoded word must not enter EX.
  // flag_illegal: value loaded into the EX-slot illegal flag when rejected.
  logic reject_insn;
  logic flag_illegal;

`ifdef CU_ILLEGAL_INSN_DET_EN
  assign reject_insn  = dec_illegal;
  assign flag_illegal = 1'b1;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
  assign reject_insn        = !dec_known;
  assign flag_illegal       = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------
  ctrl_word_t          ex_ctrl_reg;
  ctrl_word_t          ex_ctrl_next;
  logic                ex_illegal_reg;
  logic                ex_illegal_next;

  logic                mem_rd_en_reg;
  logic                mem_wr_en_reg;
  logic [FUNCT3_W-1:0] mem_size_reg;
  logic                mem_reg_wr_en_reg;
  wb_sel_e             mem_wb_sel_reg;

  logic                wb_reg_wr_en_reg;
  wb_sel_e             wb_result_sel_reg;

  // ---------------------------------------------------------------------
  // EX: branch / jump resolution against this cycle's ALU flags
  // ---------------------------------------------------------------------
  pc_src_e ex_pc_src;
  logic    ex_flush;

  always_comb begin
    ex_pc_src = PC_PLUS4;
    if (ex_ctrl_reg.is_jalr) begin
      ex_pc_src = PC_ALU;
    end else if (ex_ctrl_reg.is_jal ||
                 (ex_ctrl_reg.is_branch &&
                  branch_taken(ex_ctrl_reg.funct3, i_alu_zero_flag,
                               i_alu_lt_flag, i_alu_ltu_flag))) begin
      ex_pc_src = PC_IMM;
    end
    ex_flush = (ex_pc_src != PC_PLUS4);
  end

  // ---------------------------------------------------------------------
  // ID/EX load selection. Priority: flush > stall > invalid slot >
  // rejected instruction > decoded word. The illegal flag only survives
  // when nothing of higher priority bubbles the slot.
  // ---------------------------------------------------------------------
  always_comb begin
    ex_ctrl_next    = CTRL_BUBBLE;
    ex_illegal_next = 1'b0;
    if (ex_flush) begin
      ex_ctrl_next = CTRL_BUBBLE;
    end else if (i_stall) begin
      ex_ctrl_next = CTRL_BUBBLE;
    end else if (!i_instr_valid) begin
      ex_ctrl_next = CTRL_BUBBLE;
    end else if (reject_insn) begin
      ex_ctrl_next    = CTRL_BUBBLE;
      ex_illegal_next = flag_illegal;
    end else begin
      ex_ctrl_next = dec_ctrl;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; stall only affects ID/EX.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_ctrl_reg       <= CTRL_BUBBLE;
      ex_illegal_reg    <= 1'b0;
      mem_rd_en_reg     <= 1'b0;
      mem_wr_en_reg     <= 1'b0;
      mem_size_reg      <= '0;
      mem_reg_wr_en_reg <= 1'b0;
      mem_wb_sel_reg    <= WB_MEM;
      wb_reg_wr_en_reg  <= 1'b0;
      wb_result_sel_reg <= WB_MEM;
    end else begin
      ex_ctrl_reg       <= ex_ctrl_next;
      ex_illegal_reg    <= ex_illegal_next;
      mem_rd_en_reg     <= ex_ctrl_reg.mem_rd_en;
      mem_wr_en_reg     <= ex_ctrl_reg.mem_wr_en;
      mem_size_reg      <= ex_ctrl_reg.funct3;
      mem_reg_wr_en_reg <= ex_ctrl_reg.reg_wr_en;
      mem_wb_sel_reg    <= ex_ctrl_reg.wb_sel;
      wb_reg_wr_en_reg  <= mem_reg_wr_en_reg;
      wb_result_sel_reg <= mem_wb_sel_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_ex_alu_src_sel = ex_ctrl_reg.alu_src_sel;
  assign o_ex_alu_a_sel   = ex_ctrl_reg.alu_a_sel;
  assign o_ex_alu_op      = ex_ctrl_reg.alu_op;
  assign o_ex_pc_src      = ex_pc_src;
  assign o_ex_flush       = ex_flush;
  assign o_illegal_insn   = ex_illegal_reg;

  assign o_mem_rd_en      = mem_rd_en_reg;
  assign o_mem_wr_en      = mem_wr_en_reg;
  assign o_mem_size       = mem_size_reg;

  assign o_wb_reg_wr_en   = wb_reg_wr_en_reg;
  assign o_wb_result_sel  = wb_result_sel_reg;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       instr_valid;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall;
  logic       alu_zero;
  logic       alu_lt;
  logic       alu_ltu;

  logic [2:0] id_imm_sel;
  logic       ex_alu_src_sel;
  logic       ex_alu_a_sel;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_pc_src;
  logic       ex_flush;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [2:0] mem_size;
  logic       wb_reg_wr_en;
  logic [1:0] wb_result_sel;
  logic       illegal_insn;

  int checks = 0;
  int errors = 0;

`ifdef CU_ILLEGAL_INSN_DET_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BAD   = 7'h7f;

  pipeline_control_unit dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_instr_valid    (instr_valid),
    .i_op_code        (op_code),
    .i_funct3         (funct3),
    .i_funct7         (funct7),
    .i_stall          (stall),
    .i_alu_zero_flag  (alu_zero),
    .i_alu_lt_flag    (alu_lt),
    .i_alu_ltu_flag   (alu_ltu),
    .o_id_imm_sel     (id_imm_sel),
    .o_ex_alu_src_sel (ex_alu_src_sel),
    .o_ex_alu_a_sel   (ex_alu_a_sel),
    .o_ex_alu_op      (ex_alu_op),
    .o_ex_pc_src      (ex_pc_src),
    .o_ex_flush       (ex_flush),
    .o_mem_rd_en      (mem_rd_en),
    .o_mem_wr_en      (mem_wr_en),
    .o_mem_size       (mem_size),
    .o_wb_reg_wr_en   (wb_reg_wr_en),
    .o_wb_result_sel  (wb_result_sel),
    .o_illegal_insn   (illegal_insn)
  );

  // Expected control for one pipeline slot
  typedef struct packed {
    logic       known;
    logic       bad;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src;
    logic       alu_a;
    logic [3:0] alu_op;
    logic       br;
    logic       jal;
    logic       jalr;
    logic [2:0] f3;
    logic [1:0] wb_sel;
    logic       ill;
  } exp_t;

  // Scoreboard: entries in flight; before each cycle [0]=MEM slot, [1]=EX slot
  exp_t sb_q[$];

  function automatic exp_t model_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    exp_t e;
    e = '0;
    e.known = 1'b1;
    case (op)
      OP_R: begin
        e.reg_wr = 1; e.wb_sel = 2'b01; e.alu_op = {f7[5], f3};
        e.bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_I: begin
        e.reg_wr = 1; e.alu_src = 1; e.wb_sel = 2'b01;
        e.alu_op = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
        e.bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_LD: begin
        e.reg_wr = 1; e.mem_rd = 1; e.alu_src = 1; e.wb_sel = 2'b00; e.f3 = f3;
        e.bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      OP_ST: begin
        e.mem_wr = 1; e.alu_src = 1; e.f3 = f3;
        e.bad = (f3 > 3'd2);
      end
      OP_BR: begin
        e.br = 1; e.alu_op = 4'b1000; e.f3 = f3;
      end
      OP_JAL: begin
        e.reg_wr = 1; e.jal = 1; e.alu_a = 1; e.alu_src = 1; e.wb_sel = 2'b10;
      end
      OP_JALR: begin
        e.reg_wr = 1; e.jalr = 1; e.alu_src = 1; e.wb_sel = 2'b10;
        e.bad = (f3 != 3'd0);
      end
      OP_LUI: begin
        e.reg_wr = 1; e.alu_src = 1; e.wb_sel = 2'b11;
      end
      OP_AUIPC: begin
        e.reg_wr = 1; e.alu_a = 1; e.alu_src = 1; e.wb_sel = 2'b01;
      end
      default: e.known = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] model_pc(input exp_t e, input logic z, input logic lt,
                                          input logic ltu);
    logic taken;
    taken = 1'b0;
    if (e.br) begin
      case (e.f3)
        3'd0: taken = z;
        3'd1: taken = !z;
        3'd4: taken = lt;
        3'd5: taken = !lt;
        3'd6: taken = ltu;
        3'd7: taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
    if (e.jalr) return 2'b10;
    if (e.jal || taken) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] op, output logic has);
    has = 1'b1;
    case (op)
      OP_LD, OP_I, OP_JALR: return 3'b000;
      OP_ST:                return 3'b001;
      OP_BR:                return 3'b010;
      OP_JAL:               return 3'b011;
      OP_LUI, OP_AUIPC:     return 3'b100;
      default: begin
        has = 1'b0;
        return 3'b000;
      end
    endcase
  endfunction

  task automatic sb_reset();
    sb_q.delete();
    sb_q.push_back(exp_t'(0));
    sb_q.push_back(exp_t'(0));
  endtask

  task automatic drive_idle();
    instr_valid = 0; op_code = 0; funct3 = 0; funct7 = 0;
    stall = 0; alu_zero = 0; alu_lt = 0; alu_ltu = 0;
  endtask

  // All registered outputs must read as bubble
  task automatic check_all_bubble(input string tag);
    logic [8:0] ex_vec;
    logic [4:0] mem_vec;
    logic [3:0] wb_vec;
    ex_vec  = {ex_alu_src_sel, ex_alu_a_sel, ex_alu_op, ex_pc_src, ex_flush};
    mem_vec = {mem_rd_en, mem_wr_en, mem_size};
    wb_vec  = {wb_reg_wr_en, wb_result_sel, illegal_insn};
    checks++;
    if (ex_vec !== 9'b0) begin
      errors++;
      $display("FAIL %s ex_outputs: got %b expected %b", tag, ex_vec, 9'b0);
    end
    checks++;
    if (mem_vec !== 5'b0) begin
      errors++;
      $display("FAIL %s mem_outputs: got %b expected %b", tag, mem_vec, 5'b0);
    end
    checks++;
    if (wb_vec !== 4'b0) begin
      errors++;
      $display("FAIL %s wb_outputs: got %b expected %b", tag, wb_vec, 4'b0);
    end
  endtask

  // One ID cycle: called at a falling edge, returns at the next falling edge
  task automatic step(input logic v_i, input logic [6:0] op_i, input logic [2:0] f3_i,
                      input logic [6:0] f7_i, input logic st_i, input logic z_i,
                      input logic lt_i, input logic ltu_i, input string name);
    exp_t       d, rec, r_ex, r_mem, r_wb;
    logic [1:0] pc_e;
    logic       flush_e;
    logic [2:0] imm_e;
    logic       has_imm;

    instr_valid = v_i; op_code = op_i; funct3 = f3_i; funct7 = f7_i;
    stall = st_i; alu_zero = z_i; alu_lt = lt_i; alu_ltu = ltu_i;
    #1;
    imm_e = model_imm(op_i, has_imm);
    if (has_imm) begin
      checks++;
      if (id_imm_sel !== imm_e) begin
        errors++;
        $display("FAIL %s id_imm_sel: got %b expected %b", name, id_imm_sel, imm_e);
      end
    end
    pc_e    = model_pc(sb_q[1], z_i, lt_i, ltu_i);
    flush_e = (pc_e != 2'b00);
    checks++;
    if (ex_pc_src !== pc_e) begin
      errors++;
      $display("FAIL %s ex_pc_src: got %b expected %b", name, ex_pc_src, pc_e);
    end
    checks++;
    if (ex_flush !== flush_e) begin
      errors++;
      $display("FAIL %s ex_flush: got %b expected %b", name, ex_flush, flush_e);
    end

    d   = model_decode(op_i, f3_i, f7_i);
    rec = '0;
    if (flush_e || st_i || !v_i) rec = '0;
    else if (!d.known || (ILL_EN && d.bad)) rec.ill = ILL_EN;
    else rec = d;
    sb_q.push_back(rec);

    @(posedge clk);
    #1;
    r_ex  = sb_q[2];
    r_mem = sb_q[1];
    r_wb  = sb_q.pop_front();

    checks++;
    if (ex_alu_op !== r_ex.alu_op) begin
      errors++;
      $display("FAIL %s ex_alu_op: got %b expected %b", name, ex_alu_op, r_ex.alu_op);
    end
    checks++;
    if (ex_alu_src_sel !== r_ex.alu_src) begin
      errors++;
      $display("FAIL %s ex_alu_src_sel: got %b expected %b", name, ex_alu_src_sel, r_ex.alu_src);
    end
    checks++;
    if (ex_alu_a_sel !== r_ex.alu_a) begin
      errors++;
      $display("FAIL %s ex_alu_a_sel: got %b expected %b", name, ex_alu_a_sel, r_ex.alu_a);
    end
    checks++;
    if (illegal_insn !== r_ex.ill) begin
      errors++;
      $display("FAIL %s illegal_insn: got %b expected %b", name, illegal_insn, r_ex.ill);
    end
    checks++;
    if (mem_rd_en !== r_mem.mem_rd) begin
      errors++;
      $display("FAIL %s mem_rd_en: got %b expected %b", name, mem_rd_en, r_mem.mem_rd);
    end
    checks++;
    if (mem_wr_en !== r_mem.mem_wr) begin
      errors++;
      $display("FAIL %s mem_wr_en: got %b expected %b", name, mem_wr_en, r_mem.mem_wr);
    end
    if (r_mem.mem_rd || r_mem.mem_wr) begin
      checks++;
      if (mem_size !== r_mem.f3) begin
        errors++;
        $display("FAIL %s mem_size: got %b expected %b", name, mem_size, r_mem.f3);
      end
    end
    checks++;
    if (wb_reg_wr_en !== r_wb.reg_wr) begin
      errors++;
      $display("FAIL %s wb_reg_wr_en: got %b expected %b", name, wb_reg_wr_en, r_wb.reg_wr);
    end
    if (r_wb.reg_wr || !r_wb.known) begin
      checks++;
      if (wb_result_sel !== r_wb.wb_sel) begin
        errors++;
        $display("FAIL %s wb_result_sel: got %b expected %b", name, wb_result_sel, r_wb.wb_sel);
      end
    end

    $display("[%0t] %-10s v=%0b op=%b f3=%b f7=%b st=%0b | ex op=%b src=%0b a=%0b ill=%0b | mem rd=%0b wr=%0b sz=%b | wb wr=%0b sel=%b",
             $time, name, v_i, op_i, f3_i, f7_i, st_i, ex_alu_op, ex_alu_src_sel,
             ex_alu_a_sel, illegal_insn, mem_rd_en, mem_wr_en, mem_size,
             wb_reg_wr_en, wb_result_sel);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 7'h00, 3'd0, 7'h00, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_bubble("reset_assert");
    repeat (2) @(posedge clk);
    #1 check_all_bubble("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    sb_reset();
  endtask

  task automatic test_alu();
    step(1, OP_R, 3'd0, 7'h00, 0, 0, 0, 0, "ADD");
    step(1, OP_R, 3'd0, 7'h20, 0, 0, 0, 0, "SUB");
    step(1, OP_I, 3'd5, 7'h20, 0, 0, 0, 0, "SRAI");
    step(1, OP_I, 3'd1, 7'h00, 0, 0, 0, 0, "SLLI");
    step(1, OP_I, 3'd6, 7'h55, 0, 0, 0, 0, "ORI");
    step(1, OP_R, 3'd3, 7'h00, 0, 0, 0, 0, "SLTU");
    step(1, OP_R, 3'd5, 7'h20, 0, 0, 0, 0, "SRA");
    idle(3);
  endtask

  task automatic test_branch();
    step(1, OP_BR, 3'd1, 7'h00, 0, 0, 0, 0, "BNE");
    step(1, OP_R,  3'd0, 7'h00, 0, 0, 0, 0, "ADD_shdw");
    step(1, OP_R,  3'd7, 7'h00, 0, 0, 0, 0, "AND");
    step(1, OP_BR, 3'd1, 7'h00, 0, 0, 0, 0, "BNE");
    step(1, OP_R,  3'd0, 7'h00, 0, 1, 0, 0, "ADD_nt");
    step(1, OP_BR, 3'd4, 7'h00, 0, 0, 0, 0, "BLT");
    step(1, OP_I,  3'd0, 7'h01, 0, 0, 1, 0, "ADDI_shdw");
    step(1, OP_BR, 3'd7, 7'h00, 0, 0, 0, 0, "BGEU");
    step(1, OP_I,  3'd0, 7'h01, 0, 0, 0, 1, "ADDI_nt");
    step(1, OP_BR, 3'd2, 7'h00, 0, 0, 0, 0, "BR_010");
    step(1, OP_I,  3'd4, 7'h00, 0, 1, 1, 1, "XORI_nt");
    step(1, OP_BR, 3'd0, 7'h00, 0, 0, 0, 0, "BEQ");
    step(1, OP_R,  3'd0, 7'h00, 0, 1, 0, 0, "ADD_shdw");
    idle(3);
  endtask

  task automatic test_load_stall();
    step(1, OP_LD, 3'd2, 7'h00, 0, 0, 0, 0, "LW");
    step(1, OP_R,  3'd0, 7'h00, 1, 0, 0, 0, "ADD_stall");
    step(1, OP_R,  3'd0, 7'h00, 0, 0, 0, 0, "ADD");
    step(1, OP_ST, 3'd2, 7'h00, 0, 0, 0, 0, "SW");
    step(1, OP_LD, 3'd4, 7'h00, 0, 0, 0, 0, "LBU");
    step(1, OP_ST, 3'd0, 7'h00, 0, 0, 0, 0, "SB");
    idle(3);
  endtask

  task automatic test_jumps();
    step(1, OP_JALR,  3'd0, 7'h00, 0, 0, 0, 0, "JALR");
    step(1, OP_R,     3'd0, 7'h00, 1, 0, 0, 0, "ADD_fl_st");
    step(1, OP_R,     3'd0, 7'h00, 0, 0, 0, 0, "ADD");
    step(1, OP_JAL,   3'd5, 7'h12, 0, 0, 0, 0, "JAL");
    step(1, OP_I,     3'd0, 7'h00, 0, 0, 0, 0, "ADDI_shdw");
    step(1, OP_LUI,   3'd3, 7'h40, 0, 0, 0, 0, "LUI");
    step(1, OP_AUIPC, 3'd1, 7'h0f, 0, 0, 0, 0, "AUIPC");
    idle(3);
  endtask

  task automatic test_illegal();
    step(1, OP_BAD, 3'd0, 7'h00, 0, 0, 0, 0, "BAD_OPC");
    step(0, 7'h00,  3'd0, 7'h00, 0, 0, 0, 0, "idle");
    step(1, OP_LD,  3'd3, 7'h00, 0, 0, 0, 0, "LD_f3_011");
    step(1, OP_R,   3'd0, 7'h01, 0, 0, 0, 0, "R_f7_01");
    step(1, OP_JALR, 3'd1, 7'h00, 0, 0, 0, 0, "JALR_f3");
    step(1, OP_BAD, 3'd0, 7'h00, 1, 0, 0, 0, "BAD_stall");
    idle(3);
  endtask

  task automatic test_reset_midstream();
    step(1, OP_LD, 3'd2, 7'h00, 0, 0, 0, 0, "LW");
    step(1, OP_JAL, 3'd0, 7'h00, 0, 0, 0, 0, "JAL");
    drive_idle();
    rst_n = 1'b0;
    #1 check_all_bubble("reset_mid");
    sb_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, OP_R, 3'd0, 7'h00, 0, 0, 0, 0, "ADD_post");
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [6:0] opc_tab [10];
    logic [6:0] f7_r;
    opc_tab[0] = OP_R;   opc_tab[1] = OP_I;     opc_tab[2] = OP_LD;  opc_tab[3] = OP_ST;
    opc_tab[4] = OP_BR;  opc_tab[5] = OP_JAL;   opc_tab[6] = OP_JALR; opc_tab[7] = OP_LUI;
    opc_tab[8] = OP_AUIPC; opc_tab[9] = OP_BAD;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       f7_r = 7'h00;
        1:       f7_r = 7'h20;
        default: f7_r = 7'($urandom);
      endcase
      step($urandom_range(0, 7) != 0, opc_tab[$urandom_range(0, 9)], 3'($urandom), f7_r,
           $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), 1'($urandom), "rand");
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_stall();
    test_jumps();
    test_illegal();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Pipelined RV32I control unit, successor to the single-cycle decoder. Decodes each ID-stage instruction into a full control word. Carries that word through ID/EX, EX/MEM and MEM/WB stage registers, and resolves conditional branches and jumps in EX from ALU flags. Also inserts bubbles on hazard stalls, taken branches and invalid slots. Sits between the IF/ID register and the datapath stage muxes.

## Interface
- OP_CODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 width
- FUNCT7_WIDTH, 7, funct7 width
- ALU_OP_WIDTH, 4, ALU operation select width ({funct7[5], funct3} encoding)

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_instr_valid  in  1  ID slot holds a real instruction
- i_op_code  in  OP_CODE_WIDTH  ID-stage opcode
- i_funct3  in  FUNCT3_WIDTH  ID-stage funct3
- i_funct7  in  FUNCT7_WIDTH  ID-stage funct7
- i_stall  in  1  load-use hazard; inserts a bubble into ID/EX
- i_alu_zero_flag  in  1  EX ALU result == 0
- i_alu_lt_flag  in  1  EX signed rs1 < rs2
- i_alu_ltu_flag  in  1  EX unsigned rs1 < rs2
- o_id_imm_sel  out  3  immediate format, combinational from ID: 000 I, 001 S, 010 B, 011 J, 100 U
- o_ex_alu_src_sel  out  1  operand B: 0 rs2, 1 immediate
- o_ex_alu_a_sel  out  1  operand A: 0 rs1, 1 PC (AUIPC, JAL)
- o_ex_alu_op  out  ALU_OP_WIDTH  ALU operation
- o_ex_pc_src  out  2  00 PC+4, 01 PC+imm (taken branch/JAL), 10 ALU result (JALR)
- o_ex_flush  out  1  control transfer taken in EX; IF/ID must be flushed
- o_mem_rd_en  out  1  data-memory read
- o_mem_wr_en  out  1  data-memory write
- o_mem_size  out  FUNCT3_WIDTH  load/store width/sign (stored funct3)
- o_wb_reg_wr_en  out  1  register-file write enable
- o_wb_result_sel  out  2  00 memory, 01 ALU, 10 PC+4, 11 immediate (LUI)
- o_illegal_insn  out  1  illegal instruction reached EX (see Configuration)

## Operation
- Decode covers all RV32I: LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC.
- ALU op rules:
  - OP: {funct7[5], funct3}.
  - OP-IMM: {funct7[5] only for funct3 101, else 0, funct3}.
  - LOAD/STORE/JALR/AUIPC/JAL/LUI: 0000 (ADD).
  - BRANCH: 1000 (SUB).
- Register-file write for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC. Never for STORE, BRANCH or a bubble.
- Bubble = all enables 0, pc_src 00, alu_op 0000, stored funct3 000. It is inserted into ID/EX when any of:
  - o_ex_flush = 1
  - i_stall = 1
  - i_instr_valid = 0
  - opcode not recognised
- ID/EX load priority: flush > stall > invalid > decoded word.
- EX/MEM and MEM/WB always advance; stall never holds them.
- EX branch resolution from stored funct3:
  - BEQ zero; BNE !zero
  - BLT lt; BGE !lt
  - BLTU ltu; BGEU !ltu
  - funct3 010/011: not taken.
- JAL: pc_src 01. JALR: pc_src 10. Both always flush.
- o_ex_flush = (o_ex_pc_src != 00).

## Timing
- o_id_imm_sel: combinational, zero cycles.
- EX outputs: registered, one cycle after ID. o_ex_pc_src and o_ex_flush are combinational from the EX register and the same-cycle ALU flags.
- MEM outputs: two cycles after ID. WB outputs: three cycles after ID.
- Reset (asynchronous, immediate) sets every stage register to bubble:
  - all outputs 0, o_wb_result_sel 00, o_ex_pc_src 00, o_illegal_insn 0
  - o_id_imm_sel remains combinational
- Reset mid-operation discards all in-flight control words; first valid decode reaches EX on the first edge after release.
- Flush and stall in the same cycle: flush wins; a single bubble is inserted, which also satisfies the stall.
- Back-to-back taken branches cannot occur: the instruction behind a taken branch is always bubbled.

## Configuration
- CU_ILLEGAL_INSN_DET_EN defined: an instruction is illegal when any of:
  - opcode is unrecognised
  - R-type funct7 is not 0000000/0100000, or 0100000 is used with funct3 other than 000/101
  - OP-IMM shift has a bad funct7
  - LOAD funct3 is 011/110/111
  - STORE funct3 is above 010
  - JALR funct3 != 000
  - Required response: the illegal instruction becomes a bubble, and o_illegal_insn pulses high for one cycle in its EX slot (registered flag in ID/EX, cleared by bubble priority rules).
- Undefined: only unrecognised opcodes bubble; o_illegal_insn tied 0.

## Structure
- Package cu_pkg holds:
  - opcode and funct3 constants
  - alu_op, pc_src, wb_sel and imm_sel enums
  - packed ctrl_word_t struct and its BUBBLE constant
- Sub-module cu_decoder: pure combinational opcode/funct → ctrl_word_t plus illegal flag.
- Top level holds stage registers, bubble priority and branch resolution.

## Test plan
- Reset: assert i_reset_n=0 mid-stream → all registered outputs 0 on the same cycle; ADD (0110011/000/0000000) issued after release → o_ex_alu_op=0000 at +1, o_wb_reg_wr_en=1 with o_wb_result_sel=01 at +3.
- SUB then SRAI: R-type funct7 0100000/000 → alu_op 1000; OP-IMM funct3 101, funct7 0100000 → 1101, alu_src_sel=1.
- BNE with zero=0 → pc_src 01, flush=1, next EX slot bubble (all enables 0); with zero=1 → pc_src 00, no flush.
- LW followed by i_stall=1 for one cycle → ID/EX bubble, o_mem_rd_en=1 and o_mem_size=010 in MEM two cycles after the LW's ID cycle, wb_result_sel 00 the following cycle.
- JALR with i_stall=1 asserted while the JALR is in EX → pc_src 10, single bubble, o_wb_result_sel 10 for the JALR.
- With CU_ILLEGAL_INSN_DET_EN: opcode 1111111 → o_illegal_insn=1 for exactly one cycle, no reg/mem writes; without the macro it stays 0.
